// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: funct3 codes, FSM state encoding and init words for the data memory
package dmem_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [31:0] INIT_W0 = 32'h5555_5555;
  localparam logic [31:0] INIT_W1 = 32'hAAAA_AAAA;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bus between core MEM stage (master) and dmem_ctrl (slave)
interface dmem_ctrl_if #(parameter int ADDR_W = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_fault;
  modport master(output req_valid, req_write, req_funct3, req_addr, req_wdata,
                 input req_ready, rsp_valid, rsp_rdata, rsp_fault);
  modport slave(input req_valid, req_write, req_funct3, req_addr, req_wdata,
                output req_ready, rsp_valid, rsp_rdata, rsp_fault);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: fault decode, store byte-enables/lane replication, load lane extract+extend
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic        write,
  input  logic        in_range,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);
  logic illegal, misaligned;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ld;
  always_comb begin
    illegal = write ? !(funct3 inside {SB, SH, SW}) : !(funct3 inside {LB, LH, LW, LBU, LHU});
    misaligned = (funct3[1:0] == LH[1:0] && lane[0]) || (funct3[1:0] == LW[1:0] && lane != 2'b00);
    fault = !in_range || illegal || misaligned;
    be = funct3[1:0] == LB[1:0] ? 4'b0001 << lane : funct3[1:0] == LH[1:0] ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // replicate store data across lanes so the byte-enables pick the right copy
    wword = funct3[1:0] == SB[1:0] ? {4{wdata[7:0]}} : funct3[1:0] == SH[1:0] ? {2{wdata[15:0]}} : wdata;
    b = rword[{lane, 3'b000} +: 8];
    h = lane[1] ? rword[31:16] : rword[15:0];
    // funct3[2] marks the unsigned load variants
    ld = funct3[1:0] == LB[1:0] ? {{24{b[7] && !funct3[2]}}, b}
       : funct3[1:0] == LH[1:0] ? {{16{h[15] && !funct3[2]}}, h} : rword;
    rdata = write || fault ? '0 : ld;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed RV32I data memory; ports clk, rst (async high), bus (dmem_ctrl_if.slave)
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W = 32,
  parameter int WAIT_STATES = 0
) (
  input logic clk,
  input logic rst,
  dmem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  state_t state;
  logic [3:0] cnt;
  logic l_write;
  logic [2:0] l_f3;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] mem [DEPTH_WORDS] = '{0: INIT_W0, 1: INIT_W1, default: '0};
  logic idle, accept, fire, write, in_range, fault;
  logic [2:0] f3;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, wword, rdata;
  logic [3:0] be;
  logic [AW-1:0] idx;
  assign idle = state == IDLE;
  assign bus.req_ready = idle && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  // fire marks the edge that enters RESP: the acceptance edge itself when there are no wait states
  assign fire = WAIT_STATES == 0 ? accept : state == WAIT && cnt == '0 && !rst;
  // with no wait states the access completes on the acceptance edge, so decode the live request
  assign write = idle ? bus.req_write : l_write;
  assign f3 = idle ? bus.req_funct3 : l_f3;
  assign addr = idle ? bus.req_addr : l_addr;
  assign wdata = idle ? bus.req_wdata : l_wdata;
  assign idx = addr[AW+1:2];
  assign in_range = addr[ADDR_W-1:AW+2] == '0;
  dmem_lane_align u_align (
    .funct3(f3),
    .lane(addr[1:0]),
    .write(write),
    .in_range(in_range),
    .wdata(wdata),
    .rword(mem[idx]),
    .fault(fault),
    .be(be),
    .wword(wword),
    .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (fire && write && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      l_write <= 1'b0;
      l_f3 <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_fault <= 1'b0;
    end else begin
      bus.rsp_valid <= fire;
      if (fire) begin
        bus.rsp_rdata <= rdata;
        bus.rsp_fault <= fault;
      end
      case (state)
        IDLE: if (accept) begin
          l_write <= bus.req_write;
          l_f3 <= bus.req_funct3;
          l_addr <= bus.req_addr;
          l_wdata <= bus.req_wdata;
          cnt <= WS_LOAD;
          state <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: if (cnt == '0) state <= RESP; else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl at 0, 3 and 2 wait states
module tb_dmem_ctrl;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0, wr = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0, wd = '0;
  int sel = 0;
  int errors = 0, checks = 0;
  logic rdy, rv, ft;
  logic [31:0] rd;
  logic [31:0] r;
  logic fl, ry;
  int lat;
  always #5 clk = ~clk;
  dmem_ctrl_if b0 ();
  dmem_ctrl_if b3 ();
  dmem_ctrl_if b2 ();
  assign b0.req_valid = v && sel == 0;
  assign b3.req_valid = v && sel == 1;
  assign b2.req_valid = v && sel == 2;
  assign b0.req_write = wr;
  assign b3.req_write = wr;
  assign b2.req_write = wr;
  assign b0.req_funct3 = f3;
  assign b3.req_funct3 = f3;
  assign b2.req_funct3 = f3;
  assign b0.req_addr = addr;
  assign b3.req_addr = addr;
  assign b2.req_addr = addr;
  assign b0.req_wdata = wd;
  assign b3.req_wdata = wd;
  assign b2.req_wdata = wd;
  always_comb begin
    rdy = sel == 0 ? b0.req_ready : sel == 1 ? b3.req_ready : b2.req_ready;
    rv = sel == 0 ? b0.rsp_valid : sel == 1 ? b3.rsp_valid : b2.rsp_valid;
    rd = sel == 0 ? b0.rsp_rdata : sel == 1 ? b3.rsp_rdata : b2.rsp_rdata;
    ft = sel == 0 ? b0.rsp_fault : sel == 1 ? b3.rsp_fault : b2.rsp_fault;
  end
  dmem_ctrl #(.WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_ctrl #(.WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  dmem_ctrl #(.WAIT_STATES(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ro, output logic flo, output logic rdy1, output int n);
    @(negedge clk);
    wr = w; f3 = f; addr = a; wd = d; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    n = 0;
    rdy1 = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) rdy1 = rdy;
    end while (!rv && n < 20);
    ro = rd;
    flo = ft;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (b0.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", b0.req_ready); end
    checks++; if (b0.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", b0.rsp_valid); end
    checks++; if (b0.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", b0.rsp_rdata); end
    checks++; if (b0.rsp_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", b0.rsp_fault); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({b0.req_ready, b3.req_ready, b2.req_ready} !== 3'b111) begin errors++; $display("FAIL rel_ready got %b exp 111", {b0.req_ready, b3.req_ready, b2.req_ready}); end
  endtask

  task automatic test_load;
    sel = 0;
    access(1'b0, LW, 32'h4, 32'h0, r, fl, ry, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL lw4_latency got %0d exp 1", lat); end
    checks++; if (r !== 32'hAAAAAAAA) begin errors++; $display("FAIL lw4_rdata got %h exp aaaaaaaa", r); end
    checks++; if (fl !== 1'b0) begin errors++; $display("FAIL lw4_fault got %b exp 0", fl); end
    checks++; if (ry !== 1'b0) begin errors++; $display("FAIL lw4_ready got %b exp 0", ry); end
    @(negedge clk);
    checks++; if ({rv, rdy} !== 2'b01) begin errors++; $display("FAIL lw4_after got valid/ready %b exp 01", {rv, rdy}); end
    access(1'b0, LB, 32'h5, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb5 got %h exp ffffffaa", r); end
    access(1'b0, LBU, 32'h5, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'h000000AA) begin errors++; $display("FAIL lbu5 got %h exp 000000aa", r); end
    access(1'b0, LH, 32'h2, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'h00005555) begin errors++; $display("FAIL lh2 got %h exp 00005555", r); end
    access(1'b0, LHU, 32'h6, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'h0000AAAA) begin errors++; $display("FAIL lhu6 got %h exp 0000aaaa", r); end
    access(1'b0, LH, 32'h6, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'hFFFFAAAA) begin errors++; $display("FAIL lh6 got %h exp ffffaaaa", r); end
  endtask

  task automatic test_store;
    sel = 0;
    access(1'b1, SB, 32'h9, 32'h123456F0, r, fl, ry, lat);
    checks++; if ({lat == 1, fl, r} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL sb9_rsp got lat %0d fault %b rdata %h exp 1 0 0", lat, fl, r); end
    access(1'b0, LW, 32'h8, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'h0000F000) begin errors++; $display("FAIL sb9_lw8 got %h exp 0000f000", r); end
    access(1'b1, SH, 32'hE, 32'h0000BEEF, r, fl, ry, lat);
    access(1'b0, LW, 32'hC, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'hBEEF0000) begin errors++; $display("FAIL shE_lwC got %h exp beef0000", r); end
    access(1'b1, SW, 32'h10, 32'h01020384, r, fl, ry, lat);
    access(1'b0, LB, 32'h10, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'hFFFFFF84) begin errors++; $display("FAIL sw10_lb10 got %h exp ffffff84", r); end
  endtask

  task automatic test_fault;
    sel = 0;
    access(1'b0, LW, 32'h2, 32'h0, r, fl, ry, lat);
    checks++; if ({fl, r} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw2 got fault %b rdata %h exp 1 0", fl, r); end
    access(1'b1, SH, 32'h3, 32'hFFFF, r, fl, ry, lat);
    checks++; if ({fl, r} !== {1'b1, 32'h0}) begin errors++; $display("FAIL sh3 got fault %b rdata %h exp 1 0", fl, r); end
    access(1'b0, LW, 32'h0, 32'h0, r, fl, ry, lat);
    checks++; if ({fl, r} !== {1'b0, 32'h55555555}) begin errors++; $display("FAIL sh3_lw0 got fault %b rdata %h exp 0 55555555", fl, r); end
    access(1'b0, LW, 32'h100, 32'h0, r, fl, ry, lat);
    checks++; if ({fl, r} !== {1'b1, 32'h0}) begin errors++; $display("FAIL lw100 got fault %b rdata %h exp 1 0", fl, r); end
    access(1'b0, 3'b011, 32'h0, 32'h0, r, fl, ry, lat);
    checks++; if ({fl, r} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ld011 got fault %b rdata %h exp 1 0", fl, r); end
    access(1'b1, 3'b100, 32'h4, 32'h0, r, fl, ry, lat);
    checks++; if (fl !== 1'b1) begin errors++; $display("FAIL st100 got fault %b exp 1", fl); end
    access(1'b0, LW, 32'h4, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'hAAAAAAAA) begin errors++; $display("FAIL st100_lw4 got %h exp aaaaaaaa", r); end
    access(1'b1, SB, 32'h100, 32'h11, r, fl, ry, lat);
    checks++; if (fl !== 1'b1) begin errors++; $display("FAIL sb100 got fault %b exp 1", fl); end
    access(1'b0, LW, 32'hFC, 32'h0, r, fl, ry, lat);
    checks++; if ({fl, r} !== {1'b0, 32'h0}) begin errors++; $display("FAIL lwfc got fault %b rdata %h exp 0 0", fl, r); end
  endtask

  task automatic test_back_to_back;
    sel = 1;
    @(negedge clk);
    wr = 1'b0; f3 = LW; addr = 32'h4; v = 1'b1;
    @(posedge clk);
    #1 addr = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_ready T+%0d got %b exp 0", k, rdy); end
      checks++; if (rv !== (k == 4)) begin errors++; $display("FAIL b2b_valid T+%0d got %b exp %b", k, rv, k == 4); end
      if (k == 4) begin
        checks++; if (rd !== 32'hAAAAAAAA) begin errors++; $display("FAIL b2b_rdata1 got %h exp aaaaaaaa", rd); end
      end
    end
    @(negedge clk);
    checks++; if ({rdy, rv} !== 2'b10) begin errors++; $display("FAIL b2b_T+5 got ready/valid %b exp 10", {rdy, rv}); end
    @(posedge clk);
    #1 v = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (rv !== (k == 4)) begin errors++; $display("FAIL b2b_valid2 +%0d got %b exp %b", k, rv, k == 4); end
    end
    checks++; if (rd !== 32'h55555555) begin errors++; $display("FAIL b2b_rdata2 got %h exp 55555555", rd); end
  endtask

  task automatic test_reset_mid;
    int seen;
    sel = 2;
    @(negedge clk);
    wr = 1'b1; f3 = SW; addr = 32'hC; wd = 32'hDEADBEEF; v = 1'b1;
    @(posedge clk);
    #1 v = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", rdy); end
      end
      if (rv) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_novalid got %0d pulses exp 0", seen); end
    access(1'b0, LW, 32'hC, 32'h0, r, fl, ry, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL rmid_latency got %0d exp 3", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rmid_lwC got %h exp 00000000", r); end
    access(1'b0, LW, 32'h0, 32'h0, r, fl, ry, lat);
    checks++; if (r !== 32'h55555555) begin errors++; $display("FAIL rmid_lw0 got %h exp 55555555", r); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_store;
    test_fault;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
